// File: rtl/wir_ctrl.sv
// Wrapper instruction register controller: WIR shift/update stages, bypass register,
// WBR0 enable decode and registered serial output, with control-protocol error detection.
module wir_ctrl #(
    parameter int unsigned WIR_WIDTH = 3
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 WSI,
    input  logic                 SelectWIR,
    input  logic                 CaptureWR,
    input  logic                 ShiftWR,
    input  logic                 UpdateWR,
    input  logic                 WPSO0,
    output logic                 WPSI0,
    output logic                 wse_outputs,
    output logic                 hold_outputs,
    output logic                 BusDisable,
    output logic                 WSO,
    output logic                 proto_err,
    output logic [WIR_WIDTH-1:0] wir_active
);

    localparam logic [WIR_WIDTH-1:0] OpExtest  = WIR_WIDTH'(1);
    localparam logic [WIR_WIDTH-1:0] OpIntest  = WIR_WIDTH'(2);
    localparam logic [WIR_WIDTH-1:0] OpPreload = WIR_WIDTH'(3);
    localparam logic [WIR_WIDTH-1:0] OpSafe    = WIR_WIDTH'(4);
    localparam logic [WIR_WIDTH-1:0] OpClamp   = WIR_WIDTH'(5);

    typedef enum logic [1:0] {StIdle, StCapture, StShift, StUpdate} state_e;

    state_e               state_q, state_d;
    logic                 shift_seen_q, shift_seen_d;
    logic [WIR_WIDTH-1:0] wir_sh_q, wir_sh_d;
    logic [WIR_WIDTH-1:0] wir_act_q, wir_act_d;
    logic                 byp_q, byp_d;
    logic                 wso_q, wso_d;
    logic                 hold_q, hold_d;
    logic                 bd_q, bd_d;
    logic                 perr_q, perr_d;

    logic do_cap, do_sh, do_upd, multi, upd_ok, wbr_sel;

    function automatic logic dec_hold(input logic [WIR_WIDTH-1:0] op);
        return (op == OpExtest) || (op == OpIntest) || (op == OpClamp);
    endfunction

    function automatic logic dec_wbr(input logic [WIR_WIDTH-1:0] op);
        return (op == OpExtest) || (op == OpIntest) || (op == OpPreload);
    endfunction

    assign wbr_sel = dec_wbr(wir_act_q);

    // Priority: capture beats shift beats update; only the winner acts.
    assign do_cap = CaptureWR;
    assign do_sh  = ShiftWR & ~CaptureWR;
    assign do_upd = UpdateWR & ~CaptureWR & ~ShiftWR;
    assign multi  = (CaptureWR & ShiftWR) | (CaptureWR & UpdateWR) | (ShiftWR & UpdateWR);
    // Shift-seen flag remembers a shift as the last real operation across idle cycles.
    assign upd_ok = (state_q == StShift) || ((state_q == StIdle) && shift_seen_q);

    always_comb begin
        state_d      = StIdle;
        shift_seen_d = shift_seen_q;
        wir_sh_d     = wir_sh_q;
        wir_act_d    = wir_act_q;
        byp_d        = byp_q;
        wso_d        = wso_q;
        hold_d       = hold_q;
        bd_d         = bd_q;
        perr_d       = multi | (do_upd & ~upd_ok);

        if (do_cap) begin
            state_d      = StCapture;
            shift_seen_d = 1'b0;
            if (SelectWIR) begin
                wir_sh_d = WIR_WIDTH'(1);
            end else if (!wbr_sel) begin
                byp_d = 1'b0;
            end
        end else if (do_sh) begin
            state_d      = StShift;
            shift_seen_d = 1'b1;
            if (SelectWIR) begin
                wso_d    = wir_sh_q[0];
                wir_sh_d = {WSI, wir_sh_q[WIR_WIDTH-1:1]};
            end else if (!wbr_sel) begin
                wso_d = byp_q;
                byp_d = WSI;
            end else begin
                wso_d = WPSO0;
            end
        end else if (do_upd && upd_ok) begin
            state_d      = StUpdate;
            shift_seen_d = 1'b0;
            if (SelectWIR) begin
                wir_act_d = wir_sh_q;
                hold_d    = dec_hold(wir_sh_q);
                bd_d      = (wir_sh_q == OpSafe);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_seen_q <= 1'b0;
            wir_sh_q     <= '0;
            wir_act_q    <= '0;
            byp_q        <= 1'b0;
            wso_q        <= 1'b0;
            hold_q       <= 1'b0;
            bd_q         <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_seen_q <= shift_seen_d;
            wir_sh_q     <= wir_sh_d;
            wir_act_q    <= wir_act_d;
            byp_q        <= byp_d;
            wso_q        <= wso_d;
            hold_q       <= hold_d;
            bd_q         <= bd_d;
            perr_q       <= perr_d;
        end
    end

    assign WPSI0        = WSI;
    assign wse_outputs  = ShiftWR & ~SelectWIR & ~CaptureWR & wbr_sel;
    assign hold_outputs = hold_q;
    assign BusDisable   = bd_q;
    assign WSO          = wso_q;
    assign proto_err    = perr_q;
    assign wir_active   = wir_act_q;

endmodule

// File: tb/tb_wir_ctrl.sv
// Directed self-checking bench for wir_ctrl: WIR load, EXTEST/bypass data paths,
// protocol errors, asynchronous reset mid-shift and undefined-opcode handling.
module tb_wir_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic       WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WPSO0;
    logic       WPSI0, wse_outputs, hold_outputs, BusDisable, WSO, proto_err;
    logic [2:0] wir_active;

    int n_total = 0;
    int n_bad   = 0;

    wir_ctrl #(.WIR_WIDTH(3)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .WSI          (WSI),
        .SelectWIR    (SelectWIR),
        .CaptureWR    (CaptureWR),
        .ShiftWR      (ShiftWR),
        .UpdateWR     (UpdateWR),
        .WPSO0        (WPSO0),
        .WPSI0        (WPSI0),
        .wse_outputs  (wse_outputs),
        .hold_outputs (hold_outputs),
        .BusDisable   (BusDisable),
        .WSO          (WSO),
        .proto_err    (proto_err),
        .wir_active   (wir_active)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Apply controls, clock one edge, return 1 time unit after it.
    task automatic op(input logic sel, input logic cap, input logic sh, input logic upd,
                      input logic wsi);
        SelectWIR = sel;
        CaptureWR = cap;
        ShiftWR   = sh;
        UpdateWR  = upd;
        WSI       = wsi;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_wir(input logic [2:0] code);
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b1, 1'b0, code[i]);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [6:0] wpso_pat;
    logic [6:0] wsi_pat;
    logic [2:0] byp_pat;
    logic [2:0] byp_exp;

    initial begin
        reset = 1'b1;
        WSI = 1'b0; SelectWIR = 1'b0; CaptureWR = 1'b0; ShiftWR = 1'b0;
        UpdateWR = 1'b0; WPSO0 = 1'b0;
        #2;
        check_eq("rst_wso", 32'(WSO), 32'd0);
        check_eq("rst_wir_active", 32'(wir_active), 32'd0);
        check_eq("rst_hold", 32'(hold_outputs), 32'd0);
        check_eq("rst_busdis", 32'(BusDisable), 32'd0);
        check_eq("rst_perr", 32'(proto_err), 32'd0);
        #1 reset = 1'b0;

        // Load EXTEST bit by bit, watching the old WIR contents stream out.
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("wir_sh_wso0", 32'(WSO), 32'd1);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("wir_sh_wso1", 32'(WSO), 32'd0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("wir_sh_wso2", 32'(WSO), 32'd0);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("extest_active", 32'(wir_active), 32'd1);
        check_eq("extest_hold", 32'(hold_outputs), 32'd1);
        check_eq("extest_busdis", 32'(BusDisable), 32'd0);
        check_eq("extest_perr", 32'(proto_err), 32'd0);

        // EXTEST data shift through WBR0.
        wpso_pat = 7'b1011001;
        wsi_pat  = 7'b0110101;
        for (int i = 0; i < 7; i++) begin
            SelectWIR = 1'b0; CaptureWR = 1'b0; ShiftWR = 1'b1; UpdateWR = 1'b0;
            WPSO0 = wpso_pat[i];
            WSI   = wsi_pat[i];
            #1;
            check_eq("extest_wse", 32'(wse_outputs), 32'd1);
            check_eq("extest_wpsi", 32'(WPSI0), 32'(wsi_pat[i]));
            @(posedge CLK);
            #1;
            check_eq("extest_wso", 32'(WSO), 32'(wpso_pat[i]));
        end
        SelectWIR = 1'b1;
        #1;
        check_eq("wse_wir_sel", 32'(wse_outputs), 32'd0);
        op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wso_hold", 32'(WSO), 32'(wpso_pat[6]));

        // SAFE, then BYPASS with a one-bit data path.
        load_wir(3'd4);
        check_eq("safe_active", 32'(wir_active), 32'd4);
        check_eq("safe_busdis", 32'(BusDisable), 32'd1);
        check_eq("safe_hold", 32'(hold_outputs), 32'd0);
        load_wir(3'd0);
        check_eq("byp_active", 32'(wir_active), 32'd0);
        check_eq("byp_busdis", 32'(BusDisable), 32'd0);
        op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        byp_pat = 3'b011;
        byp_exp = 3'b110;
        for (int i = 0; i < 3; i++) begin
            SelectWIR = 1'b0; CaptureWR = 1'b0; ShiftWR = 1'b1; UpdateWR = 1'b0;
            WSI = byp_pat[i];
            #1;
            check_eq("byp_wse", 32'(wse_outputs), 32'd0);
            @(posedge CLK);
            #1;
            check_eq("byp_wso", 32'(WSO), 32'(byp_exp[i]));
        end

        // Protocol errors: capture+shift, then update straight after capture.
        op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("cap_sh_perr", 32'(proto_err), 32'd1);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("upd_after_cap_perr", 32'(proto_err), 32'd1);
        check_eq("upd_after_cap_active", 32'(wir_active), 32'd0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("perr_clear", 32'(proto_err), 32'd0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("cap_won_wso", 32'(WSO), 32'd1);

        // Asynchronous reset in the middle of a WIR shift.
        load_wir(3'd5);
        check_eq("clamp_hold", 32'(hold_outputs), 32'd1);
        check_eq("clamp_active", 32'(wir_active), 32'd5);
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("midrst_active", 32'(wir_active), 32'd0);
        check_eq("midrst_hold", 32'(hold_outputs), 32'd0);
        check_eq("midrst_wso", 32'(WSO), 32'd0);
        check_eq("midrst_perr", 32'(proto_err), 32'd0);
        #1 reset = 1'b0;
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("postrst_active", 32'(wir_active), 32'd0);
        check_eq("postrst_hold", 32'(hold_outputs), 32'd0);

        // Undefined code 7 via a 4-bit shift (wraps), updated from idle after shift.
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("undef_active", 32'(wir_active), 32'd7);
        check_eq("undef_perr", 32'(proto_err), 32'd0);
        check_eq("undef_hold", 32'(hold_outputs), 32'd0);
        check_eq("undef_busdis", 32'(BusDisable), 32'd0);
        SelectWIR = 1'b0; CaptureWR = 1'b0; ShiftWR = 1'b1; UpdateWR = 1'b0; WSI = 1'b1;
        #1;
        check_eq("undef_wse", 32'(wse_outputs), 32'd0);
        @(posedge CLK);
        #1;
        check_eq("undef_wso0", 32'(WSO), 32'd0);
        op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("undef_wso1", 32'(WSO), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
